// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller.
// Drives PC load/redirect and a req/ack imem fetch into a held instr slot.
`timescale 1ns/1ps

module fetch_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] pc,
  output logic        pc_load,
  output logic        pc_src,
  output logic [31:0] pc_target,
  input  logic        branch_req,
  input  logic [31:0] branch_off,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_REDIR,
    S_DRAIN,
    S_ERR
  } state_t;

  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_d, instr_d, tgt_d;
  logic        req_d, valid_d, load_d, src_d, err_d;
  logic        take_br;

  // redirects are honoured everywhere except before start and after error
  assign take_br = branch_req
                 & (state_q != S_IDLE)
                 & (state_q != S_ERR);

  // state and registered outputs
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_load     <= 1'b0;
      pc_src      <= 1'b0;
      pc_target   <= '0;
      fetch_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      imem_req    <= req_d;
      imem_addr   <= addr_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
      pc_load     <= load_d;
      pc_src      <= src_d;
      pc_target   <= tgt_d;
      fetch_err   <= err_d;
    end
  end

  // next state and next-cycle output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = imem_addr;
    instr_d = instr;
    tgt_d   = pc_target;
    req_d   = 1'b0;
    valid_d = 1'b0;
    load_d  = 1'b0;
    src_d   = 1'b0;
    err_d   = fetch_err;
    unique case (state_q)
      S_IDLE: state_d = S_ISSUE;
      S_ISSUE: begin
        addr_d = pc;
        if (take_br) begin
          state_d = S_REDIR;
        end else if (pc[1:0] != 2'b00) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          state_d = S_WAIT;
          req_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (imem_ack) begin
          if (take_br) begin
            state_d = S_REDIR;
          end else begin
            state_d = S_HOLD;
            instr_d = imem_rdata;
            valid_d = 1'b1;
            load_d  = 1'b1;
          end
        end else if (take_br) begin
          state_d = S_DRAIN;
          req_d   = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (take_br) begin
          state_d = S_REDIR;
        end else if (instr_ready) begin
          state_d = S_ISSUE;
        end else begin
          valid_d = 1'b1;
        end
      end
      S_REDIR: begin
        if (!take_br) state_d = S_ISSUE;
      end
      S_DRAIN: begin
        if (imem_ack) begin
          state_d = take_br ? S_REDIR : S_ISSUE;
        end else begin
          req_d = 1'b1;
        end
      end
      S_ERR: err_d = 1'b1;
      default: state_d = S_ERR;
    endcase
    // every accepted redirect yields one pc_src pulse next cycle
    if (take_br) begin
      load_d = 1'b1;
      src_d  = 1'b1;
      tgt_d  = branch_off;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed literal checks plus a randomized run
// checked against a transaction-level model of the fetch stream.
`timescale 1ns/1ps

module tb_fetch_ctrl;

  logic        clk;
  logic        areset;
  logic [31:0] pc;
  logic        pc_load;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        branch_req;
  logic [31:0] branch_off;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_err;

  fetch_ctrl #(.MAX_WAIT(4)) dut (
    .clk        (clk),
    .areset     (areset),
    .pc         (pc),
    .pc_load    (pc_load),
    .pc_src     (pc_src),
    .pc_target  (pc_target),
    .branch_req (branch_req),
    .branch_off (branch_off),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .fetch_err  (fetch_err)
  );

  int n_cmp = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register environment
  logic [31:0] pc_reg;
  logic        force_en;
  logic [31:0] force_val;
  assign pc = force_en ? force_val : pc_reg;

  always @(posedge clk or negedge areset) begin
    if (!areset) pc_reg <= 32'd0;
    else if (pc_load) pc_reg <= pc_reg + (pc_src ? pc_target : 32'd4);
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // memory responder: 0 random delay 0..2, 1 fixed delay, 2 never ack
  int mem_mode = 1;
  int fix_dly = 0;
  int dly = 0;
  bit busy = 0;

  task automatic mem_drive();
    if (imem_req && mem_mode != 2) begin
      if (!busy) begin
        busy = 1;
        dly = (mem_mode == 0) ? int'($urandom_range(0, 2)) : fix_dly;
      end
      if (dly == 0) begin
        imem_ack = 1'b1;
        imem_rdata = memf(imem_addr);
        busy = 0;
      end else begin
        imem_ack = 1'b0;
        dly--;
      end
    end else begin
      imem_ack = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    branch_req = 1'b0;
    mem_drive();
  endtask

  task automatic reset_dut();
    areset = 1'b0;
    branch_req = 1'b0;
    imem_ack = 1'b0;
    busy = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    areset = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pc_load"}, 32'(pc_load), 32'd0);
    chk({tag, "_pc_src"}, 32'(pc_src), 32'd0);
    chk({tag, "_pc_target"}, pc_target, 32'd0);
    chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
  endtask

  // transaction-level model of the fetch stream
  bit          mon_en = 0;
  logic [31:0] ref_pc, cur_addr, exp_instr, p_addr, p_instr, p_off;
  bit          p_req, p_ack, p_valid, p_ready, p_br, exp_del, squashed;
  int          n_del;

  task automatic mon_clear();
    ref_pc = 32'd0;
    cur_addr = 32'd0;
    exp_instr = 32'd0;
    p_addr = 32'd0;
    p_instr = 32'd0;
    p_off = 32'd0;
    {p_req, p_ack, p_valid, p_ready, p_br, exp_del, squashed} = '0;
    n_del = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (p_br) begin
          chk("redir_pulse", 32'(pc_load && pc_src), 32'd1);
          chk("redir_target", pc_target, p_off);
        end else if (pc_load && pc_src) begin
          chk("spurious_redir", 32'd1, 32'd0);
        end
        if (exp_del) begin
          chk("deliver_valid", 32'(instr_valid), 32'd1);
          chk("deliver_instr", instr, exp_instr);
          chk("deliver_load", 32'(pc_load && !pc_src), 32'd1);
        end else begin
          if (instr_valid && !p_valid)
            chk("unexpected_valid", 32'd1, 32'd0);
          if (pc_load && !pc_src)
            chk("unexpected_load", 32'd1, 32'd0);
        end
        if (p_valid && !p_ready && !p_br) begin
          chk("hold_valid", 32'(instr_valid), 32'd1);
          chk("hold_instr", instr, p_instr);
        end
        if (p_valid && (p_ready || p_br))
          chk("valid_drop", 32'(instr_valid), 32'd0);
        if (p_req && !p_ack) begin
          chk("req_held", 32'(imem_req), 32'd1);
          chk("addr_held", imem_addr, p_addr);
        end
        chk("no_err", 32'(fetch_err), 32'd0);
        if (imem_req && !p_req) begin
          chk("fetch_addr", imem_addr, ref_pc);
          cur_addr = imem_addr;
          squashed = 0;
        end
        if (imem_req && branch_req) squashed = 1;
        exp_del = 0;
        if (imem_req && imem_ack && !squashed) begin
          exp_del = 1;
          exp_instr = memf(cur_addr);
          ref_pc = cur_addr + 32'd4;
        end
        if (branch_req) ref_pc = ref_pc + branch_off;
        if (instr_valid && instr_ready && !branch_req) n_del++;
        p_req = imem_req;
        p_ack = imem_ack;
        p_addr = imem_addr;
        p_valid = instr_valid;
        p_instr = instr;
        p_ready = instr_ready;
        p_br = branch_req;
        p_off = branch_off;
      end
    end
  end

  int loads;

  initial begin
    areset = 1'b0;
    branch_req = 1'b0;
    branch_off = 32'd0;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    instr_ready = 1'b1;
    force_en = 1'b0;
    force_val = 32'd0;
    mon_clear();

    // reset state
    @(negedge clk);
    check_zero("reset");

    // sequential fetch 0,4,8 with immediate ack and ready=1
    mem_mode = 1;
    fix_dly = 0;
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("issue_no_req", 32'(imem_req), 32'd0);
      tick();
      @(negedge clk);
      chk("seq_req", 32'(imem_req), 32'd1);
      chk("seq_addr", imem_addr, 32'(4 * k));
      tick();
      @(negedge clk);
      chk("seq_valid", 32'(instr_valid), 32'd1);
      chk("seq_instr", instr, memf(32'(4 * k)));
      chk("seq_load", 32'(pc_load), 32'd1);
      chk("seq_src", 32'(pc_src), 32'd0);
    end

    // ready low for 5 cycles in HOLD
    tick();
    tick();
    @(negedge clk);
    chk("stall_addr", imem_addr, 32'd12);
    instr_ready = 1'b0;
    tick();
    @(negedge clk);
    loads = int'(pc_load);
    for (int j = 0; j < 5; j++) begin
      tick();
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, memf(32'd12));
      chk("stall_no_req", 32'(imem_req), 32'd0);
      loads += int'(pc_load);
    end
    chk("stall_loads", 32'(loads), 32'd1);

    // branch -8 while HOLD (pc is 16 by now)
    tick();
    branch_req = 1'b1;
    branch_off = 32'hFFFF_FFF8;
    tick();
    @(negedge clk);
    chk("br_valid_drop", 32'(instr_valid), 32'd0);
    chk("br_load", 32'(pc_load), 32'd1);
    chk("br_src", 32'(pc_src), 32'd1);
    chk("br_target", pc_target, 32'hFFFF_FFF8);
    tick();
    tick();
    @(negedge clk);
    chk("br_next_addr", imem_addr, 32'd8);
    instr_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("br_instr", instr, memf(32'd8));

    // branch +64 in WAIT, ack 3 cycles later
    fix_dly = 3;
    tick();
    tick();
    branch_req = 1'b1;
    branch_off = 32'd64;
    @(negedge clk);
    chk("drain_req0", 32'(imem_req), 32'd1);
    for (int j = 0; j < 3; j++) begin
      tick();
      @(negedge clk);
      chk("drain_req", 32'(imem_req), 32'd1);
      chk("drain_addr", imem_addr, 32'd12);
      chk("drain_valid", 32'(instr_valid), 32'd0);
      if (j == 0) begin
        chk("drain_load", 32'(pc_load && pc_src), 32'd1);
        chk("drain_target", pc_target, 32'd64);
      end else begin
        chk("drain_one_pulse", 32'(pc_load), 32'd0);
      end
    end
    fix_dly = 0;
    tick();
    @(negedge clk);
    chk("drain_discard", 32'(instr_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("drain_next_addr", imem_addr, 32'd76);
    tick();
    @(negedge clk);
    chk("drain_next_instr", instr, memf(32'd76));

    // misaligned pc
    force_en = 1'b1;
    force_val = 32'h0000_0006;
    reset_dut();
    tick();
    tick();
    @(negedge clk);
    chk("mis_err", 32'(fetch_err), 32'd1);
    chk("mis_no_req", 32'(imem_req), 32'd0);
    branch_req = 1'b1;
    branch_off = 32'd4;
    for (int j = 0; j < 4; j++) begin
      tick();
      @(negedge clk);
      chk("mis_sticky", 32'(fetch_err), 32'd1);
      chk("mis_no_load", 32'(pc_load), 32'd0);
      chk("mis_no_valid", 32'(instr_valid), 32'd0);
    end
    force_en = 1'b0;

    // timeout after 4 WAIT cycles
    mem_mode = 2;
    reset_dut();
    @(negedge clk);
    chk("rst_clears_err", 32'(fetch_err), 32'd0);
    tick();
    for (int j = 0; j < 4; j++) begin
      tick();
      @(negedge clk);
      chk("to_req", 32'(imem_req), 32'd1);
      chk("to_no_err", 32'(fetch_err), 32'd0);
    end
    tick();
    @(negedge clk);
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_no_req", 32'(imem_req), 32'd0);

    // async reset in the middle of WAIT
    reset_dut();
    tick();
    tick();
    @(negedge clk);
    chk("mid_req", 32'(imem_req), 32'd1);
    @(posedge clk);
    #2;
    areset = 1'b0;
    #1;
    check_zero("async");

    // randomized run against the fetch-stream model
    mem_mode = 0;
    instr_ready = 1'b0;
    reset_dut();
    mon_clear();
    mon_en = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) begin
        branch_req = 1'b1;
        branch_off = 32'((int'($urandom_range(0, 32)) - 16) * 4);
      end
    end
    tick();
    @(negedge clk);
    #1;
    mon_en = 0;
    chk("progress", 32'(n_del >= 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
